// File: rtl/menu_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : menu_select_ctrl
// Function : Mode-selection hand cursor: key sync, wrap/auto-repeat browsing,
//            confirm blink and valid/ack hand-off of the chosen mode.
// Revision : 1.0  initial release
// ============================================================================
module menu_select_ctrl #(
    parameter int NUM_OPTIONS    = 3,
    parameter int HAND_X         = 200,
    parameter int FIRST_Y        = 240,
    parameter int STEP_Y         = 48,
    parameter int REPEAT_FRAMES  = 12,
    parameter int BLINK_FRAMES   = 8,
    parameter int CONFIRM_BLINKS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        startOfFrame,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_enter,
    input  logic        mode_ack,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        hand_visible,
    output logic [1:0]  selected_mode,
    output logic        mode_valid
);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_BROWSE  = 2'd1;
    localparam logic [1:0] c_S_CONFIRM = 2'd2;
    localparam logic [1:0] c_S_DONE    = 2'd3;

    localparam int c_HOLD_W  = $clog2(REPEAT_FRAMES + 1);
    localparam int c_BLINK_W = $clog2(BLINK_FRAMES + 1);
    localparam int c_HALF_W  = $clog2(2 * CONFIRM_BLINKS + 1);

    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(REPEAT_FRAMES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [c_HALF_W-1:0]  c_HALF_LAST  = c_HALF_W'(2 * CONFIRM_BLINKS - 1);
    localparam logic [1:0]           c_IDX_LAST   = 2'(NUM_OPTIONS - 1);
    localparam logic [10:0]          c_HAND_X     = 11'(HAND_X);
    localparam logic [10:0]          c_FIRST_Y    = 11'(FIRST_Y);
    localparam logic [10:0]          c_STEP_Y     = 11'(STEP_Y);

    // Key vector bit order: 0 = up, 1 = down, 2 = enter
    logic [2:0]           r_sync1, r_sync2, r_prev, r_edge;
    logic [1:0]           r_state, w_state_next;
    logic [1:0]           r_index, w_index_next, w_index_up, w_index_dn;
    logic [10:0]          r_y;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [c_BLINK_W-1:0] r_blink;
    logic [c_HALF_W-1:0]  r_half;
    logic                 w_browse, w_one_held, w_repeat, w_step_up, w_step_dn;
    logic                 w_confirm, w_half_end, w_blink_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= {key_enter, key_down, key_up};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 & ~r_prev;
        end
    end

    // Auto-repeat only runs while exactly one direction key is held
    assign w_browse   = (r_state == c_S_BROWSE) && enable;
    assign w_one_held = r_sync2[0] ^ r_sync2[1];
    assign w_repeat   = w_browse && w_one_held && startOfFrame && (r_hold == c_HOLD_LAST);
    assign w_step_up  = r_edge[0] | (w_repeat & r_sync2[0]);
    assign w_step_dn  = r_edge[1] | (w_repeat & r_sync2[1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else if (!(w_browse && w_one_held)) begin
            r_hold <= '0;
        end else if (startOfFrame) begin
            r_hold <= w_repeat ? '0 : r_hold + 1'b1;
        end
    end

    // r_half counts completed blink half-periods; its LSB is the visible phase
    assign w_confirm    = (r_state == c_S_CONFIRM) && enable;
    assign w_half_end   = w_confirm && startOfFrame && (r_blink == c_BLINK_LAST);
    assign w_blink_done = w_half_end && (r_half == c_HALF_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink <= '0;
            r_half  <= '0;
        end else if (!w_confirm) begin
            r_blink <= '0;
            r_half  <= '0;
        end else if (startOfFrame) begin
            if (w_half_end) begin
                r_blink <= '0;
                r_half  <= r_half + 1'b1;
            end else begin
                r_blink <= r_blink + 1'b1;
            end
        end
    end

    assign w_index_up = (r_index == 2'd0) ? c_IDX_LAST : r_index - 1'b1;
    assign w_index_dn = (r_index == c_IDX_LAST) ? 2'd0 : r_index + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        case (r_state)
            c_S_IDLE: begin
                if (enable) w_state_next = c_S_BROWSE;
            end
            c_S_BROWSE: begin
                if (!enable)                     w_state_next = c_S_IDLE;
                else if (r_edge[2])              w_state_next = c_S_CONFIRM;
                else if (w_step_up && !w_step_dn) w_index_next = w_index_up;
                else if (w_step_dn && !w_step_up) w_index_next = w_index_dn;
            end
            c_S_CONFIRM: begin
                if (!enable)          w_state_next = c_S_IDLE;
                else if (w_blink_done) w_state_next = c_S_DONE;
            end
            c_S_DONE: begin
                if (!enable || mode_ack) w_state_next = c_S_IDLE;
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_index <= 2'd0;
            r_y     <= c_FIRST_Y;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_y     <= c_FIRST_Y + 11'(w_index_next) * c_STEP_Y;
        end
    end

    always_comb begin
        hand_visible = 1'b0;
        case (r_state)
            c_S_BROWSE:  hand_visible = 1'b1;
            c_S_CONFIRM: hand_visible = r_half[0];
            c_S_DONE:    hand_visible = 1'b1;
            default:     hand_visible = 1'b0;
        endcase
    end

    assign topLeftX      = c_HAND_X;
    assign topLeftY      = r_y;
    assign selected_mode = r_index;
    assign mode_valid    = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_menu_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_select_ctrl
// Function : Self-checking bench for menu_select_ctrl (vector table, directed
//            corner sequences, randomized run against a reference model).
// Revision : 1.0  initial release
// ============================================================================
module tb_menu_select_ctrl;

    localparam int NUM_OPTIONS    = 3;
    localparam int HAND_X         = 200;
    localparam int FIRST_Y        = 240;
    localparam int STEP_Y         = 48;
    localparam int REPEAT_FRAMES  = 12;
    localparam int BLINK_FRAMES   = 8;
    localparam int CONFIRM_BLINKS = 3;
    localparam int RAND_CYCLES    = 4000;

    logic        clk = 1'b0;
    logic        reset, enable, startOfFrame, key_up, key_down, key_enter, mode_ack;
    logic [10:0] topLeftX, topLeftY;
    logic        hand_visible, mode_valid;
    logic [1:0]  selected_mode;

    int n_cmp = 0;
    int n_err = 0;

    menu_select_ctrl #(
        .NUM_OPTIONS   (NUM_OPTIONS),
        .HAND_X        (HAND_X),
        .FIRST_Y       (FIRST_Y),
        .STEP_Y        (STEP_Y),
        .REPEAT_FRAMES (REPEAT_FRAMES),
        .BLINK_FRAMES  (BLINK_FRAMES),
        .CONFIRM_BLINKS(CONFIRM_BLINKS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .startOfFrame (startOfFrame),
        .key_up       (key_up),
        .key_down     (key_down),
        .key_enter    (key_enter),
        .mode_ack     (mode_ack),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .hand_visible (hand_visible),
        .selected_mode(selected_mode),
        .mode_valid   (mode_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One video frame: four clocks with the start-of-frame pulse on the last
    task automatic frame();
        repeat (3) tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic tap(input logic up, input logic dn, input int frames);
        key_up   = up;
        key_down = dn;
        repeat (frames) frame();
        key_up   = 1'b0;
        key_down = 1'b0;
        repeat (8) tick();
    endtask

    function automatic int row_y(input int idx);
        return FIRST_Y + idx * STEP_Y;
    endfunction

    // ---------------- reference model (rule level, one call per clock edge) ----
    bit hu[5], hd[5], he[5];
    int m_st, m_idx, m_hold, m_cf;  // m_st: 0 idle, 1 browse, 2 confirm, 3 done

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            hu[i] = 0; hd[i] = 0; he[i] = 0;
        end
        m_st = 0; m_idx = 0; m_hold = 0; m_cf = 0;
    endtask

    task automatic model_step();
        bit pu, pd, pe, lu, ld, rep, su, sd;
        for (int i = 4; i > 0; i--) begin
            hu[i] = hu[i-1]; hd[i] = hd[i-1]; he[i] = he[i-1];
        end
        hu[0] = key_up; hd[0] = key_down; he[0] = key_enter;
        // press acts three edges after the raw rise; held level seen two edges later
        pu = hu[3] && !hu[4];
        pd = hd[3] && !hd[4];
        pe = he[3] && !he[4];
        lu = hu[2];
        ld = hd[2];
        rep = 0;
        case (m_st)
            0: if (enable) m_st = 1;
            1: begin
                if (!enable) begin
                    m_st = 0;
                end else begin
                    if (lu != ld) begin
                        if (startOfFrame) begin
                            m_hold++;
                            if (m_hold == REPEAT_FRAMES) begin
                                rep = 1;
                                m_hold = 0;
                            end
                        end
                    end else begin
                        m_hold = 0;
                    end
                    if (pe) begin
                        m_st = 2;
                        m_cf = 0;
                    end else begin
                        su = pu || (rep && lu);
                        sd = pd || (rep && ld);
                        if (su && !sd)      m_idx = (m_idx + NUM_OPTIONS - 1) % NUM_OPTIONS;
                        else if (sd && !su) m_idx = (m_idx + 1) % NUM_OPTIONS;
                    end
                end
            end
            2: begin
                if (!enable) m_st = 0;
                else if (startOfFrame) begin
                    m_cf++;
                    if (m_cf == 2 * CONFIRM_BLINKS * BLINK_FRAMES) m_st = 3;
                end
            end
            default: if (!enable || mode_ack) m_st = 0;
        endcase
        if (m_st != 1) m_hold = 0;
    endtask

    function automatic int model_pack();
        int vis;
        case (m_st)
            0:       vis = 0;
            2:       vis = (m_cf / BLINK_FRAMES) % 2;
            default: vis = 1;
        endcase
        return (HAND_X << 15) | (row_y(m_idx) << 4) | (vis << 3) | (m_idx << 1) | (m_st == 3 ? 1 : 0);
    endfunction

    typedef struct {
        string      name;
        logic       up;
        logic       dn;
        int         frames;
        int         exp_sel;
        int         exp_y;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"down 1->2",          1'b0, 1'b1, 1,  2, 336};
        vecs[1] = '{"down wrap 2->0",     1'b0, 1'b1, 1,  0, 240};
        vecs[2] = '{"up wrap 0->2",       1'b1, 1'b0, 1,  2, 336};
        vecs[3] = '{"both held 30 fr",    1'b1, 1'b1, 30, 2, 336};
        vecs[4] = '{"up 2->1",            1'b1, 1'b0, 1,  1, 288};
        vecs[5] = '{"up 1->0",            1'b1, 1'b0, 1,  0, 240};
        vecs[6] = '{"down hold 25 fr",    1'b0, 1'b1, 25, 0, 240};
        vecs[7] = '{"up hold 13 fr",      1'b1, 1'b0, 13, 1, 288};
        vecs[8] = '{"down hold 12 fr",    1'b0, 1'b1, 12, 0, 240};

        reset = 1'b1; enable = 1'b0; startOfFrame = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0; mode_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset X", int'(topLeftX), HAND_X);
        chk("reset Y", int'(topLeftY), FIRST_Y);
        chk("reset vis", int'(hand_visible), 0);
        chk("reset sel", int'(selected_mode), 0);
        chk("reset valid", int'(mode_valid), 0);

        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        chk("ack in idle ignored", int'(hand_visible), 0);
        enable = 1'b1;
        tick();
        chk("enable vis", int'(hand_visible), 1);
        chk("enable Y", int'(topLeftY), FIRST_Y);
        chk("enable valid", int'(mode_valid), 0);

        // press latency: raw rise sampled at edge k, move lands at edge k+3
        key_down = 1'b1;
        repeat (3) tick();
        chk("latency k+2 Y", int'(topLeftY), 240);
        tick();
        chk("latency k+3 Y", int'(topLeftY), 288);
        key_down = 1'b0;
        repeat (6) tick();

        for (int v = 0; v < 9; v++) begin
            tap(vecs[v].up, vecs[v].dn, vecs[v].frames);
            chk({vecs[v].name, " sel"}, int'(selected_mode), vecs[v].exp_sel);
            chk({vecs[v].name, " Y"}, int'(topLeftY), vecs[v].exp_y);
        end

        // confirm blink at index 1, with direction keys pressed mid-blink
        tap(1'b0, 1'b1, 1);
        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        chk("ack in browse ignored", int'(mode_valid), 0);
        key_enter = 1'b1;
        repeat (5) tick();
        key_enter = 1'b0;
        for (int h = 0; h < 2 * CONFIRM_BLINKS; h++) begin
            chk($sformatf("blink half %0d vis", h), int'(hand_visible), h % 2);
            chk($sformatf("blink half %0d valid", h), int'(mode_valid), 0);
            for (int f = 0; f < BLINK_FRAMES; f++) begin
                if (f == 0 && h == 1) key_up = 1'b1;
                if (f == 0 && h == 3) key_down = 1'b1;
                if (f == 4) begin
                    key_up = 1'b0;
                    key_down = 1'b0;
                end
                frame();
            end
        end
        chk("done vis", int'(hand_visible), 1);
        chk("done valid", int'(mode_valid), 1);
        chk("done sel", int'(selected_mode), 1);
        repeat (100) tick();
        chk("done held valid", int'(mode_valid), 1);
        chk("done held Y", int'(topLeftY), 288);
        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        chk("ack drops valid", int'(mode_valid), 0);
        chk("ack to idle vis", int'(hand_visible), 0);
        tick();
        chk("re-browse vis", int'(hand_visible), 1);

        // enable dropped mid-confirm keeps the index
        tap(1'b0, 1'b1, 1);
        key_enter = 1'b1;
        repeat (5) tick();
        key_enter = 1'b0;
        repeat (10) frame();
        chk("pre-drop vis", int'(hand_visible), 1);
        enable = 1'b0;
        tick();
        chk("drop vis", int'(hand_visible), 0);
        chk("drop valid", int'(mode_valid), 0);
        chk("drop sel kept", int'(selected_mode), 2);
        enable = 1'b1;
        tick();
        chk("re-enable vis", int'(hand_visible), 1);
        chk("re-enable Y", int'(topLeftY), 336);

        // asynchronous reset in DONE
        key_enter = 1'b1;
        repeat (5) tick();
        key_enter = 1'b0;
        repeat (2 * CONFIRM_BLINKS * BLINK_FRAMES) frame();
        chk("pre-reset valid", int'(mode_valid), 1);
        #3 reset = 1'b1;
        #1;
        chk("async reset valid", int'(mode_valid), 0);
        chk("async reset vis", int'(hand_visible), 0);
        chk("async reset Y", int'(topLeftY), FIRST_Y);
        chk("async reset sel", int'(selected_mode), 0);
        tick();

        // randomized run against the reference model
        key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0; mode_ack = 1'b0;
        enable = 1'b1;
        tick();
        model_reset();
        reset = 1'b0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            startOfFrame = (c % 4 == 3);
            if ($urandom_range(63) == 0)  key_up    = ~key_up;
            if ($urandom_range(63) == 0)  key_down  = ~key_down;
            if ($urandom_range(127) == 0) key_enter = ~key_enter;
            mode_ack = ($urandom_range(31) == 0);
            if (enable) begin
                if ($urandom_range(299) == 0) enable = 1'b0;
            end else if ($urandom_range(7) == 0) begin
                enable = 1'b1;
            end
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("random cycle %0d packed", c),
                int'({topLeftX, topLeftY, hand_visible, selected_mode, mode_valid}),
                model_pack());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
